// File: rtl/seq_divider.sv
// Sequential signed divider: 16-bit dividend by 8-bit divisor, restoring algorithm,
// one quotient bit per clock, with divide-by-zero and quotient-overflow flags.
module seq_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] N,
  input  logic [7:0]  D,
  output logic        busy,
  output logic        valid,
  output logic [15:0] Q,
  output logic [7:0]  R,
  output logic        dbz,
  output logic        ovf
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [16:0] rem_q, rem_d;
  logic [15:0] dvd_q, dvd_d;   // |N| shifting out, quotient bits shifting in
  logic [7:0]  dsr_q, dsr_d;
  logic        neg_q_q, neg_q_d;
  logic        neg_r_q, neg_r_d;
  logic        dz_q, dz_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [15:0] q_q, q_d;
  logic [7:0]  r_q, r_d;
  logic        dbz_q, dbz_d;
  logic        ovf_q, ovf_d;

  logic [16:0] n_ext, n_abs;
  logic [8:0]  d_ext, d_abs;
  logic [16:0] rem_sh, trial;

  // 17-bit magnitudes so that |-32768| is represented exactly.
  assign n_ext  = {N[15], N};
  assign n_abs  = n_ext[16] ? -n_ext : n_ext;
  assign d_ext  = {D[7], D};
  assign d_abs  = d_ext[8] ? -d_ext : d_ext;
  assign rem_sh = {rem_q[15:0], dvd_q[15]};
  assign trial  = rem_sh - {9'd0, dsr_q};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          neg_q_d = N[15] ^ D[7];
          neg_r_d = N[15];
          rem_d   = '0;
          count_d = '0;
          busy_d  = 1'b1;
          dsr_d   = d_abs[7:0];
          if (D == 8'd0) begin
            // Raw N is kept so its low byte can be returned as the remainder.
            dz_d    = 1'b1;
            dvd_d   = N;
            state_d = StFix;
          end else begin
            dz_d    = 1'b0;
            dvd_d   = n_abs[15:0];
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d   = trial[16] ? rem_sh : trial;
        dvd_d   = {dvd_q[14:0], ~trial[16]};
        count_d = count_q + 4'd1;
        if (count_q == 4'd15) state_d = StFix;
      end
      StFix: begin
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
        if (dz_q) begin
          q_d   = neg_r_q ? 16'h8000 : 16'h7FFF;
          r_d   = dvd_q[7:0];
          dbz_d = 1'b1;
          ovf_d = 1'b0;
        end else if (!neg_q_q && dvd_q[15]) begin
          // Only -32768 / -1 yields a positive magnitude of 32768.
          q_d   = 16'h7FFF;
          r_d   = 8'd0;
          dbz_d = 1'b0;
          ovf_d = 1'b1;
        end else begin
          q_d   = neg_q_q ? -dvd_q : dvd_q;
          r_d   = neg_r_q ? -rem_q[7:0] : rem_q[7:0];
          dbz_d = 1'b0;
          ovf_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      count_q <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign Q     = q_q;
  assign R     = r_q;
  assign dbz   = dbz_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results queued at start, checked on valid.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] N = '0;
  logic [7:0]  D = '0;
  logic        busy, valid, dbz, ovf;
  logic [15:0] Q;
  logic [7:0]  R;

  seq_divider dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .N    (N),
    .D    (D),
    .busy (busy),
    .valid(valid),
    .Q    (Q),
    .R    (R),
    .dbz  (dbz),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    logic        ovf;
    int          start_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Call just after a negedge; start is sampled at the next posedge.
  task automatic do_op(input logic signed [15:0] n, input logic signed [7:0] d);
    exp_t e;
    int   ni, di;
    ni = n;
    di = d;
    if (di == 0) begin
      e.q = (ni >= 0) ? 16'h7FFF : 16'h8000;
      e.r = n[7:0];
      e.dbz = 1'b1; e.ovf = 1'b0; e.lat = 1;
    end else if (ni == -32768 && di == -1) begin
      e.q = 16'h7FFF; e.r = 8'd0;
      e.dbz = 1'b0; e.ovf = 1'b1; e.lat = 17;
    end else begin
      e.q = 16'(ni / di);
      e.r = 8'(ni % di);
      e.dbz = 1'b0; e.ovf = 1'b0; e.lat = 17;
    end
    N = n;
    D = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.start_cyc = cyc;
    sb.push_back(e);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      check("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic run_op(input logic signed [15:0] n, input logic signed [7:0] d);
    @(negedge clk);
    do_op(n, d);
    wait_idle();
    @(negedge clk);
    check("hold_q", 32'(Q), 32'(last.q));
    check("hold_valid", 32'(valid), 32'd0);
  endtask

  always @(negedge clk) begin
    if (valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'(valid), 32'd0);
      end else begin
        last = sb.pop_front();
        check("q", 32'(Q), 32'(last.q));
        check("r", 32'(R), 32'(last.r));
        check("dbz", 32'(dbz), 32'(last.dbz));
        check("ovf", 32'(ovf), 32'(last.ovf));
        check("latency", 32'(cyc - last.start_cyc), 32'(last.lat));
        check("busy_done", 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_q", 32'(Q), 32'd0);
    check("rst_r", 32'(R), 32'd0);
    check("rst_flags", 32'({dbz, ovf}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op(16'sd100, 8'sd7);
    run_op(-16'sd100, 8'sd7);
    run_op(16'sd1000, -8'sd3);
    run_op(-16'sd1000, -8'sd3);
    run_op(16'h8000, -8'sd1);
    run_op(16'h8000, 8'sd1);
    run_op(16'sd32767, -8'sd128);
    run_op(16'sd500, 8'sd0);
    run_op(-16'sd5, 8'sd0);
    run_op(16'sd0, -8'sd5);
    run_op(-16'sd6, 8'sd3);

    // Start re-pulsed mid-operation must be ignored.
    @(negedge clk);
    do_op(16'sd12345, 8'sd97);
    repeat (5) @(negedge clk);
    check("busy_mid", 32'(busy), 32'd1);
    N = 16'd1; D = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Back-to-back: second start issued in the valid cycle.
    @(negedge clk);
    do_op(16'sd1000, -8'sd3);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid) break;
    end
    do_op(-16'sd1000, -8'sd3);
    wait_idle();

    // Reset in the middle of CALC aborts with no valid.
    @(negedge clk);
    do_op(16'sd100, 8'sd7);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.pop_back();
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_q", 32'(Q), 32'd0);
    check("abort_r", 32'(R), 32'd0);
    check("abort_flags", 32'({dbz, ovf}), 32'd0);
    repeat (20) @(negedge clk);
    check("abort_no_valid", 32'(valid), 32'd0);
    rst = 1'b1;
    run_op(16'sd81, 8'sd9);

    for (int i = 0; i < 8; i++) begin
      run_op(16'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
